octave_upsample_reader: RTL and testbench

OCTAVE_UPSAMPLE_READER -- requirements
Module: octave_upsample_reader

---
 rtl/octave_upsample_reader_pkg.sv | 20 ++
 rtl/octave_upsample_reader_if.sv | 17 +
 rtl/octave_upsample_reader_ping_pong_line_ram.sv | 28 ++
 rtl/octave_upsample_reader.sv | 76 +++++++
 tb/tb_octave_upsample_reader.sv | 134 +++++++++++++
 5 files changed

// File: rtl/octave_upsample_reader_pkg.sv
// Shared octave parameters: coarse line width, line-RAM address width and the
// legal down-sample range, used by every octave block.
package octave_upsample_reader_pkg;

  localparam int coordW = 10;

  function automatic int coarseWidth(input int frameW, input int downS);
    return frameW >> downS;
  endfunction

  // A one-entry line still needs a one-bit address.
  function automatic int addrWidth(input int cw);
    return (cw > 1) ? $clog2(cw) : 1;
  endfunction

  function automatic bit downSLegal(input int downS);
    return (downS >= 1) && (downS <= 4);
  endfunction

endpackage

// File: rtl/octave_upsample_reader_if.sv
// Pixel stream into the upsample reader and the replicated pixel out of it.
interface octave_upsample_reader_if
  import octave_upsample_reader_pkg::*;
#(
  parameter int dataW = 8
);
  logic              en;
  logic [coordW-1:0] X;
  logic [coordW-1:0] Y;
  logic              sampleEn;
  logic [dataW-1:0]  dataIn;
  logic [dataW-1:0]  dataOut;
  logic              dataValid;

  modport master (output en, X, Y, sampleEn, dataIn, input dataOut, dataValid);
  modport slave  (input en, X, Y, sampleEn, dataIn, output dataOut, dataValid);
endinterface

// File: rtl/octave_upsample_reader_ping_pong_line_ram.sv
// Two coarse-line banks: one write port, one registered read port.
// Written as a plain RAM template so it maps onto block RAM.
module ping_pong_line_ram #(
  parameter int dataW = 8,
  parameter int depth = 320,
  parameter int addrW = 9
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic             wrBank,
  input  logic [addrW-1:0] wrAddr,
  input  logic [dataW-1:0] wrData,
  input  logic             rdEn,
  input  logic             rdBank,
  input  logic [addrW-1:0] rdAddr,
  output logic [dataW-1:0] rdData
);

  logic [dataW-1:0] mem [2][depth];

  // NOTE: the array has no reset branch on purpose; a reset would stop it
  // from mapping onto block RAM, and stale contents are masked downstream.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrBank][wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdBank][rdAddr];
  end

endmodule

// File: rtl/octave_upsample_reader.sv
// Replicates a down-sampled octave stream back to full resolution, delaying it
// by one coarse line through a ping-pong line buffer.
module octave_upsample_reader
  import octave_upsample_reader_pkg::*;
#(
  parameter int downS  = 1,
  parameter int dataW  = 8,
  parameter int frameW = 640
) (
  input logic                   clk,
  input logic                   rst_p,
  octave_upsample_reader_if.slave pix
);

  localparam int CW = coarseWidth(frameW, downS);
  localparam int AW = addrWidth(CW);
  localparam logic [coordW-1:0] cwLimit = coordW'(CW);

  if (!downSLegal(downS)) begin : gBadDownS
    $error("octave_upsample_reader: downS must be in 1..4");
  end

  logic [coordW-1:0] cx, cy;
  logic              inRange, frameStart;
  logic              armed, rowReady, rowReadyNext;
  logic              validQ, zeroOut;
  logic [dataW-1:0]  ramQ;

  assign cx         = pix.X >> downS;
  assign cy         = pix.Y >> downS;
  assign inRange    = cx < cwLimit;
  assign frameStart = (pix.X == '0) && (pix.Y == '0);

  // Read and write always hit opposite banks, so no bypass is needed.
  ping_pong_line_ram #(.dataW(dataW), .depth(CW), .addrW(AW)) u_lineRam (
    .clk    (clk),
    .wrEn   (pix.en & pix.sampleEn & inRange & ~rst_p),
    .wrBank (cy[0]),
    .wrAddr (cx[AW-1:0]),
    .wrData (pix.dataIn),
    .rdEn   (pix.en & inRange & ~rst_p),
    .rdBank (~cy[0]),
    .rdAddr (cx[AW-1:0]),
    .rdData (ramQ)
  );

  // The frame-start clear wins over the set so the first pixel is invalid.
  always_comb begin
    rowReadyNext = rowReady;
    if (pix.en) begin
      if (frameStart)                rowReadyNext = 1'b0;
      else if (armed && cy != '0)    rowReadyNext = 1'b1;
    end
  end

  // armed blocks rowReady after a reset until a fresh frame start is seen.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      armed    <= 1'b0;
      rowReady <= 1'b0;
      validQ   <= 1'b0;
      zeroOut  <= 1'b1;
    end else begin
      rowReady <= rowReadyNext;
      validQ   <= pix.en & rowReadyNext & inRange;
      if (pix.en) begin
        zeroOut <= ~inRange;
        if (frameStart) armed <= 1'b1;
      end
    end
  end

  assign pix.dataOut   = zeroOut ? '0 : ramQ;
  assign pix.dataValid = validQ;

endmodule

// File: tb/tb_octave_upsample_reader.sv
// Directed bench: instance A runs downS=1/frameW=8, instance B downS=2/frameW=16.
module tb_octave_upsample_reader;
  import octave_upsample_reader_pkg::*;

  logic clk = 1'b0;
  logic rstA = 1'b1;
  logic rstB = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  octave_upsample_reader_if #(.dataW(8)) ifA ();
  octave_upsample_reader_if #(.dataW(8)) ifB ();

  octave_upsample_reader #(.downS(1), .dataW(8), .frameW(8)) dutA (
    .clk(clk), .rst_p(rstA), .pix(ifA.slave));
  octave_upsample_reader #(.downS(2), .dataW(8), .frameW(16)) dutB (
    .clk(clk), .rst_p(rstB), .pix(ifB.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel on instance sel, clock it, and sample 1 ns after the edge.
  task automatic step(input int sel, input logic rst, input logic e, input int x,
                      input int y, input logic se, input int d);
    if (sel == 0) begin
      rstA = rst; ifA.en = e; ifA.X = coordW'(x); ifA.Y = coordW'(y);
      ifA.sampleEn = se; ifA.dataIn = 8'(d);
    end else begin
      rstB = rst; ifB.en = e; ifB.X = coordW'(x); ifB.Y = coordW'(y);
      ifB.sampleEn = se; ifB.dataIn = 8'(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input int sel, input string tag, input logic expV,
                          input logic chkData, input int expD);
    logic v;
    logic [7:0] o;
    v = (sel == 0) ? ifA.dataValid : ifB.dataValid;
    o = (sel == 0) ? ifA.dataOut : ifB.dataOut;
    check({tag, " valid"}, {31'd0, v}, {31'd0, expV});
    if (chkData) check({tag, " data"}, {24'd0, o}, expD);
  endtask

  // One full line; a sample is written on every column aligned to the factor.
  task automatic line(input int sel, input int y, input logic doWr,
                      input int wr[4], input logic expV, input int ex[4]);
    int width = (sel == 0) ? 8 : 16;
    int sh = (sel == 0) ? 1 : 2;
    for (int x = 0; x < width; x++) begin
      step(sel, 1'b0, 1'b1, x, y, doWr && (x % (1 << sh) == 0), wr[x >> sh]);
      checkOut(sel, $sformatf("%s y%0d x%0d", (sel == 0) ? "A" : "B", y, x),
               expV, expV, ex[x >> sh]);
    end
  endtask

  int none[4] = '{0, 0, 0, 0};
  int rowA[4] = '{10, 20, 30, 40};
  int rowB[4] = '{50, 60, 70, 80};
  int rowC[4] = '{1, 2, 3, 4};

  initial begin
    ifA.en = 0; ifA.X = '0; ifA.Y = '0; ifA.sampleEn = 0; ifA.dataIn = '0;
    ifB.en = 0; ifB.X = '0; ifB.Y = '0; ifB.sampleEn = 0; ifB.dataIn = '0;

    // Reset state, with en high to show reset dominates
    step(0, 1'b1, 1'b1, 2, 2, 1'b0, 0);
    step(0, 1'b1, 1'b1, 3, 2, 1'b0, 0);
    checkOut(0, "A reset", 1'b0, 1'b1, 0);

    // Frame 1: Y=0 writes row A, Y=1 idle, Y=2 replays row A and writes row B
    line(0, 0, 1'b1, rowA, 1'b0, none);
    line(0, 1, 1'b0, none, 1'b0, none);
    line(0, 2, 1'b1, rowB, 1'b1, '{10, 20, 30, 40});

    // Y=3 with an en gap mid-line and an out-of-range write at X=8
    for (int x = 0; x < 4; x++) begin
      step(0, 1'b0, 1'b1, x, 3, 1'b0, 0);
      checkOut(0, $sformatf("A y3 x%0d", x), 1'b1, 1'b1, rowA[x >> 1]);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
      checkOut(0, $sformatf("A gap%0d", i), 1'b0, 1'b1, 20);
    end
    for (int x = 4; x < 8; x++) begin
      step(0, 1'b0, 1'b1, x, 3, 1'b0, 0);
      checkOut(0, $sformatf("A y3 x%0d", x), 1'b1, 1'b1, rowA[x >> 1]);
    end
    step(0, 1'b0, 1'b1, 8, 3, 1'b1, 99);
    checkOut(0, "A y3 x8 out of range", 1'b0, 1'b1, 0);

    // Row B appears on Y=4,5 intact (the X=8 write must not have aliased)
    line(0, 4, 1'b0, none, 1'b1, rowB);
    line(0, 5, 1'b0, none, 1'b1, rowB);

    // Mid-stream frame restart masks stale data until cy != 0
    line(0, 0, 1'b0, none, 1'b0, none);
    line(0, 1, 1'b0, none, 1'b0, none);
    for (int x = 0; x < 3; x++) begin
      step(0, 1'b0, 1'b1, x, 2, 1'b0, 0);
      checkOut(0, $sformatf("A f2 y2 x%0d", x), 1'b1, 1'b1, rowA[x >> 1]);
    end

    // Reset pulsed at Y=2, X=3
    step(0, 1'b1, 1'b1, 3, 2, 1'b0, 0);
    checkOut(0, "A mid-line reset", 1'b0, 1'b1, 0);
    step(0, 1'b0, 1'b1, 4, 2, 1'b0, 0);
    checkOut(0, "A after reset, no frame start", 1'b0, 1'b0, 0);
    line(0, 0, 1'b0, none, 1'b0, none);
    line(0, 1, 1'b0, none, 1'b0, none);
    step(0, 1'b0, 1'b1, 0, 2, 1'b0, 0);
    checkOut(0, "A f3 y2 x0", 1'b1, 1'b1, 10);
    step(0, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    // downS=2: coarse row 1,2,3,4 replicated over four columns and rows 4..7
    step(1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
    checkOut(1, "B reset", 1'b0, 1'b1, 0);
    line(1, 0, 1'b1, rowC, 1'b0, none);
    for (int y = 1; y < 4; y++) line(1, y, 1'b0, none, 1'b0, none);
    for (int y = 4; y < 8; y++) line(1, y, 1'b0, none, 1'b1, rowC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
